i2c_master_t: RTL and testbench

//  Single-master I2C initiator for the i2c_mux test environment; the opposite end of i2c_slave_t.

---
 rtl/i2c_master_t.sv | 261 ++++++++++++++++++++++++++
 tb/tb_i2c_master_t.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_t.sv
// i2c_master_t: single-master I2C initiator issuing one register write
// (S, addr+W, offset, data, P) or one register read
// (S, addr+W, offset, Sr, addr+R, data, NACK, P) per accepted request.
// oSCL/oSDA are open-drain enables: 0 pulls the line low, 1 releases it.
`timescale 1ns/1ps

module i2c_master_t #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       iClk,
    input  logic       iRstn,
    input  logic       iSCL,
    input  logic       iSDA,
    output logic       oSCL,
    output logic       oSDA,
    input  logic       iStart,
    input  logic       iRw,
    input  logic [6:0] iSlaveAddr,
    input  logic [7:0] iOffset,
    input  logic [7:0] iWrData,
    output logic [7:0] oRdData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAckErr
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR_W,
        S_ACK_A,
        S_OFFS,
        S_ACK_O,
        S_WDATA,
        S_ACK_D,
        S_RSTART,
        S_ADDR_R,
        S_ACK_R,
        S_RDATA,
        S_MNACK,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [1:0]       r_q;       // quarter within the current bit cell / sequence
    logic [2:0]       r_bit;     // bit index within the current byte
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;
    logic             r_ack;     // last value sampled in Q2
    logic             r_err;     // any NACK seen in this transaction
    logic             r_rw;
    logic [6:0]       r_addr;
    logic [7:0]       r_offs;
    logic [7:0]       r_wdata;

    logic             w_bitcell;
    logic             w_ackslot;
    logic             w_hold;
    logic             w_tick;

    // Classify the current state as a 4-quarter bit cell and/or a slave ACK slot
    always_comb begin
        w_bitcell = 1'b0;
        w_ackslot = 1'b0;
        case (r_state)
            S_ADDR_W, S_OFFS, S_WDATA, S_ADDR_R, S_RDATA, S_MNACK: w_bitcell = 1'b1;
            S_ACK_A, S_ACK_O, S_ACK_D, S_ACK_R: begin
                w_bitcell = 1'b1;
                w_ackslot = 1'b1;
            end
            default: begin
                w_bitcell = 1'b0;
                w_ackslot = 1'b0;
            end
        endcase
    end

    // Divider freezes while SCL is released but still held low by a slave
    assign w_hold = !iSCL && ((w_bitcell && (r_q == 2'd2)) ||
                              (((r_state == S_STOP) || (r_state == S_RSTART)) && (r_q == 2'd1)));
    assign w_tick = (r_state != S_IDLE) && !w_hold && (r_div == DIV_MAX);

    // Quarter-period divider, running only during a transaction
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_div <= '0;
        end else if (r_state == S_IDLE) begin
            r_div <= '0;
        end else if (!w_hold) begin
            r_div <= (r_div == DIV_MAX) ? '0 : r_div + DIV_W'(1);
        end
    end

    // Transaction FSM with registered bus drives and status outputs
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_state <= S_IDLE;
            r_q     <= 2'd0;
            r_bit   <= 3'd0;
            r_tx    <= 8'd0;
            r_rx    <= 8'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= 7'd0;
            r_offs  <= 8'd0;
            r_wdata <= 8'd0;
            oSCL    <= 1'b1;
            oSDA    <= 1'b1;
            oRdData <= 8'd0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oAckErr <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (r_state == S_IDLE) begin
                oBusy <= 1'b0;
                oSCL  <= 1'b1;
                oSDA  <= 1'b1;
                // oBusy is still high during the oDone cycle, so a request there is dropped
                if (iStart && !oBusy) begin
                    r_rw    <= iRw;
                    r_addr  <= iSlaveAddr;
                    r_offs  <= iOffset;
                    r_wdata <= iWrData;
                    r_err   <= 1'b0;
                    oAckErr <= 1'b0;
                    oBusy   <= 1'b1;
                    r_q     <= 2'd0;
                    r_state <= S_START;
                end
            end else if (w_tick) begin
                r_q <= r_q + 2'd1;
                case (r_state)
                    S_START: begin
                        case (r_q)
                            2'd0: oSDA <= 1'b0;
                            2'd1: oSCL <= 1'b0;
                            default: begin
                                r_q     <= 2'd0;
                                r_bit   <= 3'd0;
                                r_tx    <= {r_addr, 1'b0};
                                oSDA    <= r_addr[6];
                                r_state <= S_ADDR_W;
                            end
                        endcase
                    end
                    S_RSTART: begin
                        case (r_q)
                            2'd0: oSCL <= 1'b1;
                            2'd1: oSDA <= 1'b0;
                            2'd2: oSCL <= 1'b0;
                            default: begin
                                r_bit   <= 3'd0;
                                r_tx    <= {r_addr, 1'b1};
                                oSDA    <= r_addr[6];
                                r_state <= S_ADDR_R;
                            end
                        endcase
                    end
                    S_STOP: begin
                        case (r_q)
                            2'd0: oSCL <= 1'b1;
                            2'd1: oSDA <= 1'b1;
                            default: begin
                                r_state <= S_IDLE;
                                oDone   <= 1'b1;
                                oAckErr <= r_err;
                            end
                        endcase
                    end
                    default: begin
                        case (r_q)
                            2'd0: oSCL <= 1'b1;
                            2'd1: oSCL <= 1'b1;
                            2'd2: begin
                                oSCL  <= 1'b0;
                                r_ack <= iSDA;
                                if (r_state == S_RDATA) r_rx <= {r_rx[6:0], iSDA};
                                if (w_ackslot && iSDA) r_err <= 1'b1;
                            end
                            default: begin
                                // End of bit cell: choose the next cell and set SDA for its Q0
                                case (r_state)
                                    S_ADDR_W, S_OFFS, S_WDATA, S_ADDR_R: begin
                                        if (r_bit == 3'd7) begin
                                            oSDA <= 1'b1;
                                            case (r_state)
                                                S_ADDR_W: r_state <= S_ACK_A;
                                                S_OFFS:   r_state <= S_ACK_O;
                                                S_WDATA:  r_state <= S_ACK_D;
                                                default:  r_state <= S_ACK_R;
                                            endcase
                                        end else begin
                                            r_bit <= r_bit + 3'd1;
                                            r_tx  <= {r_tx[6:0], 1'b0};
                                            oSDA  <= r_tx[6];
                                        end
                                    end
                                    S_ACK_A: begin
                                        if (r_ack) begin
                                            oSDA    <= 1'b0;
                                            r_state <= S_STOP;
                                        end else begin
                                            r_bit   <= 3'd0;
                                            r_tx    <= r_offs;
                                            oSDA    <= r_offs[7];
                                            r_state <= S_OFFS;
                                        end
                                    end
                                    S_ACK_O: begin
                                        if (r_ack) begin
                                            oSDA    <= 1'b0;
                                            r_state <= S_STOP;
                                        end else if (!r_rw) begin
                                            r_bit   <= 3'd0;
                                            r_tx    <= r_wdata;
                                            oSDA    <= r_wdata[7];
                                            r_state <= S_WDATA;
                                        end else begin
                                            oSDA    <= 1'b1;
                                            r_state <= S_RSTART;
                                        end
                                    end
                                    S_ACK_R: begin
                                        if (r_ack) begin
                                            oSDA    <= 1'b0;
                                            r_state <= S_STOP;
                                        end else begin
                                            r_bit   <= 3'd0;
                                            oSDA    <= 1'b1;
                                            r_state <= S_RDATA;
                                        end
                                    end
                                    S_RDATA: begin
                                        oSDA <= 1'b1;
                                        if (r_bit == 3'd7) begin
                                            oRdData <= r_rx;
                                            r_state <= S_MNACK;
                                        end else begin
                                            r_bit <= r_bit + 3'd1;
                                        end
                                    end
                                    default: begin
                                        oSDA    <= 1'b0;
                                        r_state <= S_STOP;
                                    end
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_t.sv
// tb_i2c_master_t: directed + randomized bench for i2c_master_t with a
// behavioural open-drain bus, a register slave at 0x23 and a bus monitor.
`timescale 1ns/1ps

module tb_i2c_master_t;

    localparam int unsigned DIV     = 4;
    localparam logic [6:0]  SADDR   = 7'h23;
    localparam int          STRETCH = 1000;
    localparam int          LIMIT   = 4000;
    localparam int          EV_S    = -1;
    localparam int          EV_P    = -2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       oSCL, oSDA;
    logic       iStart, iRw;
    logic [6:0] iSlaveAddr;
    logic [7:0] iOffset, iWrData;
    logic [7:0] oRdData;
    logic       oBusy, oDone, oAckErr;

    logic       s_scl_drv, s_sda_drv;
    logic       w_scl, w_sda;
    assign w_scl = oSCL & s_scl_drv;
    assign w_sda = oSDA & s_sda_drv;

    always #5 clk = ~clk;

    i2c_master_t #(.CLK_DIV(DIV)) dut (
        .iClk(clk), .iRstn(rst_n), .iSCL(w_scl), .iSDA(w_sda),
        .oSCL(oSCL), .oSDA(oSDA), .iStart(iStart), .iRw(iRw),
        .iSlaveAddr(iSlaveAddr), .iOffset(iOffset), .iWrData(iWrData),
        .oRdData(oRdData), .oBusy(oBusy), .oDone(oDone), .oAckErr(oAckErr)
    );

    // Slave at SADDR: ACKs every byte it receives, returns s_tx_data on read,
    // optionally stretches SCL at the ACK of the offset byte.
    logic       s_stretch_en;
    logic [7:0] s_tx_data;
    logic       s_prev_scl, s_prev_sda, s_active, s_tx_mode, s_rd;
    int         s_bitcnt, s_byte_idx, s_stretch_cnt;
    logic [7:0] s_rx, s_txsh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_scl_drv <= 1'b1; s_sda_drv <= 1'b1;
            s_prev_scl <= 1'b1; s_prev_sda <= 1'b1;
            s_active <= 1'b0; s_tx_mode <= 1'b0; s_rd <= 1'b0;
            s_bitcnt <= 0; s_byte_idx <= 0; s_stretch_cnt <= 0;
            s_rx <= 8'd0; s_txsh <= 8'd0;
        end else begin
            s_prev_scl <= w_scl;
            s_prev_sda <= w_sda;
            if (s_stretch_cnt > 0) begin
                s_stretch_cnt <= s_stretch_cnt - 1;
                if (s_stretch_cnt == 1) s_scl_drv <= 1'b1;
            end
            if (s_prev_scl && w_scl && s_prev_sda && !w_sda) begin
                s_active <= 1'b1; s_tx_mode <= 1'b0; s_rd <= 1'b0;
                s_bitcnt <= 0; s_byte_idx <= 0; s_sda_drv <= 1'b1;
            end else if (s_prev_scl && w_scl && !s_prev_sda && w_sda) begin
                s_active <= 1'b0; s_sda_drv <= 1'b1;
            end else if (s_active && !s_prev_scl && w_scl) begin
                if (s_bitcnt < 8) s_rx <= {s_rx[6:0], w_sda};
                s_bitcnt <= s_bitcnt + 1;
            end else if (s_active && s_prev_scl && !w_scl) begin
                if (s_bitcnt == 8) begin
                    if (s_tx_mode) s_sda_drv <= 1'b1;
                    else if (s_byte_idx == 0) begin
                        if (s_rx[7:1] == SADDR) begin
                            s_sda_drv <= 1'b0;
                            s_rd <= s_rx[0];
                        end else s_active <= 1'b0;
                    end else begin
                        s_sda_drv <= 1'b0;
                        if (s_byte_idx == 1 && s_stretch_en) begin
                            s_scl_drv <= 1'b0;
                            s_stretch_cnt <= STRETCH;
                        end
                    end
                end else if (s_bitcnt == 9) begin
                    s_bitcnt <= 0;
                    s_byte_idx <= s_byte_idx + 1;
                    if (!s_tx_mode && s_rd) begin
                        s_tx_mode <= 1'b1;
                        s_sda_drv <= s_tx_data[7];
                        s_txsh <= {s_tx_data[6:0], 1'b0};
                    end else begin
                        s_sda_drv <= 1'b1;
                        if (s_tx_mode) s_active <= 1'b0;
                    end
                end else if (s_tx_mode) begin
                    s_sda_drv <= s_txsh[7];
                    s_txsh <= {s_txsh[6:0], 1'b0};
                end
            end
        end
    end

    // Bus monitor: logs START/STOP and each 9-bit frame as byte*2+ack
    int         mon_q[$];
    logic       m_prev_scl = 1'b1, m_prev_sda = 1'b1, m_prev_oscl = 1'b1;
    logic [7:0] m_sh = 8'd0;
    int         m_bits = 0;
    int         stretch_toggles = 0;

    always @(posedge clk) begin
        m_prev_scl  <= w_scl;
        m_prev_sda  <= w_sda;
        m_prev_oscl <= oSCL;
        if (s_stretch_cnt != 0 && oSCL !== m_prev_oscl) stretch_toggles <= stretch_toggles + 1;
        if (m_prev_scl && w_scl && m_prev_sda && !w_sda) begin
            mon_q.push_back(EV_S);
            m_bits <= 0;
        end else if (m_prev_scl && w_scl && !m_prev_sda && w_sda) begin
            mon_q.push_back(EV_P);
            m_bits <= 0;
        end else if (!m_prev_scl && w_scl) begin
            if (m_bits == 8) begin
                mon_q.push_back(int'({m_sh, w_sda}));
                m_bits <= 0;
            end else begin
                m_sh   <= {m_sh[6:0], w_sda};
                m_bits <= m_bits + 1;
            end
        end
    end

    int         n_assert = 0;
    int         n_fail   = 0;
    int         exp_q[$];
    logic [7:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int enc(input int byte_val, input int ack);
        return byte_val * 2 + ack;
    endfunction

    // Reference bus transcript from the request and the slave's presence
    task automatic build_exp(input bit rw, input logic [6:0] a, input logic [7:0] off,
                             input logic [7:0] dat, input logic [7:0] rdv);
        int addr_w;
        addr_w = int'(a) * 2;
        exp_q.delete();
        exp_q.push_back(EV_S);
        if (a != SADDR) begin
            exp_q.push_back(enc(addr_w, 1));
        end else begin
            exp_q.push_back(enc(addr_w, 0));
            exp_q.push_back(enc(int'(off), 0));
            if (!rw) exp_q.push_back(enc(int'(dat), 0));
            else begin
                exp_q.push_back(EV_S);
                exp_q.push_back(enc(addr_w + 1, 0));
                exp_q.push_back(enc(int'(rdv), 1));
            end
        end
        exp_q.push_back(EV_P);
    endtask

    task automatic run_txn(input bit rw, input logic [6:0] a, input logic [7:0] off,
                           input logic [7:0] dat, input bit stretch, input string tag,
                           output int dur);
        int cyc;
        bit done;
        int base;
        int n;
        bit present;
        present = (a == SADDR);
        build_exp(rw, a, off, dat, s_tx_data);
        @(negedge clk);
        s_stretch_en = stretch;
        base = mon_q.size();
        iRw = rw; iSlaveAddr = a; iOffset = off; iWrData = dat; iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        iRw = ~rw; iSlaveAddr = 7'($urandom); iOffset = 8'($urandom); iWrData = 8'($urandom);
        check({tag, "_busy_after_accept"}, 32'(oBusy), 32'd1);
        cyc = 1; done = 1'b0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (oDone) done = 1'b1;
        end
        dur = cyc;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(oBusy), 32'd1);
        check({tag, "_ackerr"}, 32'(oAckErr), 32'(!present));
        if (present && rw) exp_rd = s_tx_data;
        check({tag, "_rddata"}, 32'(oRdData), 32'(exp_rd));
        check({tag, "_nevents"}, 32'(mon_q.size() - base), 32'(exp_q.size()));
        n = (mon_q.size() - base < exp_q.size()) ? mon_q.size() - base : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_event%0d", tag, i), 32'(mon_q[base + i]), 32'(exp_q[i]));
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 32'(oDone), 32'd0);
        check({tag, "_busy_end"}, 32'(oBusy), 32'd0);
        s_stretch_en = 1'b0;
    endtask

    initial begin
        int d0, d1, dtmp, tog0, base, cyc;
        bit busy_seen;
        rst_n = 1'b0; iStart = 1'b0; iRw = 1'b0;
        iSlaveAddr = 7'd0; iOffset = 8'd0; iWrData = 8'd0;
        s_stretch_en = 1'b0; s_tx_data = 8'hA5; exp_rd = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(oSCL), 32'd1);
        check("rst_sda", 32'(oSDA), 32'd1);
        check("rst_rd", 32'(oRdData), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_ackerr", 32'(oAckErr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(1'b0, 7'h23, 8'h10, 8'h5A, 1'b0, "wr", d0);
        run_txn(1'b1, 7'h23, 8'h00, 8'h00, 1'b0, "rd", dtmp);
        run_txn(1'b0, 7'h24, 8'h10, 8'h5A, 1'b0, "wr_absent", dtmp);
        run_txn(1'b1, 7'h24, 8'h00, 8'h00, 1'b0, "rd_absent", dtmp);

        // Stretch begins at the ACK falling edge, overlapping about three master quarters
        tog0 = stretch_toggles;
        run_txn(1'b0, 7'h23, 8'h10, 8'h5A, 1'b1, "stretch", d1);
        check("stretch_oscl_edges", 32'(stretch_toggles - tog0), 32'd1);
        check("stretch_duration", 32'((d1 - d0 >= STRETCH - 3 * int'(DIV) - 4) &&
                                      (d1 - d0 <= STRETCH + 4)), 32'd1);

        // Request while busy is dropped; async reset mid-offset byte
        @(negedge clk);
        base = mon_q.size();
        iRw = 1'b0; iSlaveAddr = 7'h23; iOffset = 8'h10; iWrData = 8'h77; iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (20) @(negedge clk);
        iStart = 1'b1; iRw = 1'b1; iSlaveAddr = 7'h24;
        @(negedge clk);
        iStart = 1'b0;
        cyc = 0;
        while (mon_q.size() - base < 2 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_first_byte_seen", 32'(mon_q.size() - base >= 2), 32'd1);
        if (mon_q.size() - base >= 2) begin
            check("abort_ev0", 32'(mon_q[base]), 32'(EV_S));
            check("abort_addr_byte", 32'(mon_q[base + 1]), 32'(enc(8'h46, 0)));
        end
        repeat (3 * 4 * DIV) @(negedge clk);
        check("abort_busy_in_offs", 32'(oBusy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_rst_scl", 32'(oSCL), 32'd1);
        check("abort_rst_sda", 32'(oSDA), 32'd1);
        check("abort_rst_busy", 32'(oBusy), 32'd0);
        check("abort_rst_rd", 32'(oRdData), 32'd0);
        exp_rd = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (oBusy || oDone) busy_seen = 1'b1;
        end
        check("abort_no_queued_req", 32'(busy_seen), 32'd0);
        run_txn(1'b0, 7'h23, 8'h3C, 8'hC3, 1'b0, "after_rst", dtmp);

        // Randomized requests, about half aimed at the present slave
        for (int k = 0; k < 8; k++) begin
            logic [6:0] ra;
            ra = ($urandom_range(0, 1) == 1) ? SADDR : 7'($urandom);
            s_tx_data = 8'($urandom);
            run_txn(1'($urandom), ra, 8'($urandom), 8'($urandom), 1'b0,
                    $sformatf("rnd%0d", k), dtmp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
